artec_dma_upsizer: RTL and testbench

ARTEC_DMA_UPSIZER -- requirements
Module: artec_dma_upsizer

---
 rtl/artec_dma_pkg.sv | 39 +++
 rtl/artec_vr_reg.sv | 46 ++++
 rtl/artec_dma_upsizer.sv | 160 ++++++++++++++++
 tb/tb_artec_dma_upsizer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/artec_dma_pkg.sv
// Shared types for the DMA datapath: settings, beat info, the upsizer word slice
// and its FSM state, plus class-scoped parametrised typedefs.
package artec_dma_pkg;

  localparam int unsigned PKG_FB_NUM = 4;
  localparam int unsigned FNUM_W     = (PKG_FB_NUM > 1) ? $clog2(PKG_FB_NUM) : 1;

  typedef struct packed {
    logic              eof;
    logic [FNUM_W-1:0] fnum;
  } info_t;

  typedef struct packed {
    logic clear;
  } common_settings_t;

  typedef struct packed {
    common_settings_t common;
  } settings_t;

  typedef enum logic {
    UPSZ_FILL   = 1'b0,
    UPSZ_CLOSED = 1'b1
  } upsz_state_e;

  // Counter wide enough to hold 0..MAX_VALUE inclusive.
  virtual class cnt_cl #(parameter int unsigned MAX_VALUE = 1);
    typedef logic [$clog2(MAX_VALUE + 1)-1:0] cnt_t;
  endclass

  virtual class upsz_cl #(parameter int unsigned DATA_W = 256, parameter int unsigned LANES = 8);
    typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [LANES-1:0]  mask;
      info_t             info;
    } upsz_slice_t;
  endclass

endpackage

// File: rtl/artec_vr_reg.sv
// One-entry valid/ready register: accepts a new entry whenever it is empty or
// being drained in the same cycle, so a full pipeline runs without bubbles.
module artec_vr_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/artec_dma_upsizer.sv
// Packs narrow stream beats into wide lane words (beat k -> lane k) and hands
// each completed or flushed word to a one-entry output register.
module artec_dma_upsizer
  import artec_dma_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH   = 32,
  parameter int unsigned OUTPUT_WIDTH  = 256,
  parameter int unsigned FLUSH_TIMEOUT = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  settings_t                           settings_i,
  input  logic [INPUT_WIDTH-1:0]              axis_i_tdata,
  input  info_t                               axis_i_tuser,
  input  logic                                axis_i_tvalid,
  output logic                                axis_i_tready,
  output logic [OUTPUT_WIDTH-1:0]             stream_o_data,
  output logic [OUTPUT_WIDTH/INPUT_WIDTH-1:0] stream_o_mask,
  output info_t                               stream_o_info,
  output logic                                stream_o_valid,
  input  logic                                stream_o_ready,
  output logic [FNUM_W-1:0]                   frame_num_o,
  output logic                                busy_o
);

  localparam int unsigned LANES = OUTPUT_WIDTH / INPUT_WIDTH;
  localparam int unsigned TMO_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

  typedef cnt_cl#(.MAX_VALUE(LANES))::cnt_t lane_cnt_t;
  typedef upsz_cl#(.DATA_W(OUTPUT_WIDTH), .LANES(LANES))::upsz_slice_t slice_t;

  if ((OUTPUT_WIDTH < INPUT_WIDTH) || ((OUTPUT_WIDTH % INPUT_WIDTH) != 0)) begin : g_bad_width
    $error("artec_dma_upsizer: OUTPUT_WIDTH must be a positive multiple of INPUT_WIDTH");
  end

  upsz_state_e       state_q;
  upsz_state_e       state_d;
  lane_cnt_t         lane_q;
  lane_cnt_t         lane_d;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_d;
  slice_t            acc_q;
  slice_t            acc_d;

  logic              srst;
  logic              accept;
  logic [LANES-1:0]  beat_lane;
  logic [OUTPUT_WIDTH-1:0] beat_data;
  slice_t            merged;
  logic              last_lane;
  logic              tmo_hit;
  logic              close;
  logic              push;
  slice_t            push_word;
  logic              out_in_ready;
  logic              out_valid;
  slice_t            out_word;

  // Soft clear is treated exactly like reset for every flop in the block.
  assign srst          = rst | settings_i.common.clear;
  assign axis_i_tready = (state_q == UPSZ_FILL);
  assign accept        = axis_i_tvalid & axis_i_tready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign beat_lane[gi] = accept && (lane_q == lane_cnt_t'(gi));
    assign beat_data[gi*INPUT_WIDTH +: INPUT_WIDTH] = beat_lane[gi] ? axis_i_tdata : '0;
  end

  always_comb begin
    merged      = acc_q;
    merged.data = acc_q.data | beat_data;
    merged.mask = acc_q.mask | beat_lane;
    merged.info = accept ? axis_i_tuser : acc_q.info;
  end

  assign last_lane = (lane_q == lane_cnt_t'(LANES - 1));
  // A timeout flush only fires on an idle cycle, so it keeps the last beat's info.
  assign tmo_hit   = (FLUSH_TIMEOUT != 0) && !accept && (lane_q != '0) &&
                     (tmo_q == TMO_W'(FLUSH_TIMEOUT - 1));
  assign close     = (state_q == UPSZ_FILL) &&
                     ((accept && (last_lane || axis_i_tuser.eof)) || tmo_hit);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    tmo_d     = tmo_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_word = merged;
    case (state_q)
      UPSZ_FILL: begin
        if (accept) begin
          tmo_d = '0;
        end else if ((FLUSH_TIMEOUT != 0) && (lane_q != '0)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (close) begin
          lane_d = '0;
          tmo_d  = '0;
          if (out_in_ready) begin
            push  = 1'b1;
            acc_d = '0;
          end else begin
            acc_d   = merged;
            state_d = UPSZ_CLOSED;
          end
        end else if (accept) begin
          acc_d  = merged;
          lane_d = lane_q + lane_cnt_t'(1);
        end
      end
      UPSZ_CLOSED: begin
        push_word = acc_q;
        if (out_in_ready) begin
          push    = 1'b1;
          acc_d   = '0;
          state_d = UPSZ_FILL;
        end
      end
      default: begin
        state_d = UPSZ_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= UPSZ_FILL;
      lane_q  <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
    end
  end

  artec_vr_reg #(
    .WIDTH ($bits(slice_t))
  ) u_out_reg (
    .clk       (clk),
    .rst       (srst),
    .in_valid  (push),
    .in_ready  (out_in_ready),
    .in_data   (push_word),
    .out_valid (out_valid),
    .out_ready (stream_o_ready),
    .out_data  (out_word)
  );

  assign stream_o_valid = out_valid;
  assign stream_o_data  = out_word.data;
  assign stream_o_mask  = out_word.mask;
  assign stream_o_info  = out_word.info;
  assign frame_num_o    = out_word.info.fnum;
  assign busy_o         = (lane_q != '0) || (state_q == UPSZ_CLOSED) || out_valid;

endmodule

// File: tb/tb_artec_dma_upsizer.sv
// Directed bench for the 32->256 upsizer with a 10-cycle flush timeout.
module tb_artec_dma_upsizer;
  import artec_dma_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  settings_t         settings;
  logic [31:0]       tdata;
  info_t             tuser;
  logic              tvalid;
  logic              tready;
  logic [255:0]      o_data;
  logic [7:0]        o_mask;
  info_t             o_info;
  logic              o_valid;
  logic              o_ready;
  logic [FNUM_W-1:0] frame_num;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [255:0]      data;
    logic [7:0]        mask;
    logic [FNUM_W-1:0] fnum;
    logic [FNUM_W-1:0] info_fnum;
    logic              eof;
    int                cyc;
  } word_t;

  word_t got_q[$];

  artec_dma_upsizer #(
    .INPUT_WIDTH   (32),
    .OUTPUT_WIDTH  (256),
    .FLUSH_TIMEOUT (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .settings_i     (settings),
    .axis_i_tdata   (tdata),
    .axis_i_tuser   (tuser),
    .axis_i_tvalid  (tvalid),
    .axis_i_tready  (tready),
    .stream_o_data  (o_data),
    .stream_o_mask  (o_mask),
    .stream_o_info  (o_info),
    .stream_o_valid (o_valid),
    .stream_o_ready (o_ready),
    .frame_num_o    (frame_num),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change on negedges, so negedge+1 sees what the next edge will see.
  always begin
    @(negedge clk);
    #1;
    if (o_valid && o_ready && !rst && !settings.common.clear) begin
      got_q.push_back('{o_data, o_mask, frame_num, o_info.fnum, o_info.eof, cyc});
      $display("word %0d: mask=%h fnum=%0d eof=%0d cyc=%0d data=%h",
               got_q.size() - 1, o_mask, frame_num, o_info.eof, cyc, o_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input logic eof, input int fn, output int acc_cyc);
    int guard;
    guard  = 0;
    tvalid = 1'b1;
    tdata  = d;
    tuser.eof  = eof;
    tuser.fnum = FNUM_W'(fn);
    while (!tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_beat_timeout: beat %h not accepted, tready=%b required 1", d, tready);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
      @(negedge clk);
    end
  endtask

  task automatic wait_words(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 300) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    settings = '0;
    tvalid = 1'b0;
    tdata = '0;
    tuser = '0;
    o_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", o_valid); end
    n_checks++; if (tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b required 1", tready); end
    n_checks++; if (frame_num !== '0) begin n_fail++; $display("FAIL reset_fnum: got %0d required 0", frame_num); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_words();
    int c, first, c7, last;
    got_q.delete();
    o_ready = 1'b1;
    first = 0; c7 = 0; last = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(32'(i), 1'b0, 1, c);
      if (i == 0) first = c;
      if (i == 7) c7 = c;
      if (i == 15) last = c;
    end
    tvalid = 1'b0;
    wait_words(2);
    repeat (3) @(negedge clk);
    n_checks++; if (last - first !== 15) begin n_fail++; $display("FAIL full_no_bubbles: span %0d cycles required 15", last - first); end
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL full_word_count: got %0d required 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0].data !== 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000) begin
        n_fail++; $display("FAIL full_w0_data: got %h", got_q[0].data); end
      n_checks++; if (got_q[1].data !== 256'h0000000F_0000000E_0000000D_0000000C_0000000B_0000000A_00000009_00000008) begin
        n_fail++; $display("FAIL full_w1_data: got %h", got_q[1].data); end
      n_checks++; if (got_q[0].mask !== 8'hFF || got_q[1].mask !== 8'hFF) begin
        n_fail++; $display("FAIL full_mask: got %h/%h required ff/ff", got_q[0].mask, got_q[1].mask); end
      n_checks++; if (got_q[0].cyc - c7 !== 1) begin
        n_fail++; $display("FAIL full_latency: got %0d cycles required 1", got_q[0].cyc - c7); end
      n_checks++; if (got_q[1].cyc - got_q[0].cyc !== 8) begin
        n_fail++; $display("FAIL full_word_spacing: got %0d cycles required 8", got_q[1].cyc - got_q[0].cyc); end
      n_checks++; if (got_q[1].fnum !== 2'd1) begin
        n_fail++; $display("FAIL full_fnum: got %0d required 1", got_q[1].fnum); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_idle: got %b required 0", busy); end
  endtask

  task automatic test_eof_partial();
    int c, c3;
    got_q.delete();
    o_ready = 1'b1;
    send_beat(32'hA1, 1'b0, 2, c);
    send_beat(32'hA2, 1'b0, 2, c);
    send_beat(32'hA3, 1'b1, 2, c3);
    tvalid = 1'b0;
    wait_words(1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL eof_word_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0].data !== 256'h000000A3_000000A2_000000A1) begin
        n_fail++; $display("FAIL eof_data: got %h", got_q[0].data); end
      n_checks++; if (got_q[0].mask !== 8'h07) begin n_fail++; $display("FAIL eof_mask: got %h required 07", got_q[0].mask); end
      n_checks++; if (got_q[0].fnum !== 2'd2) begin n_fail++; $display("FAIL eof_frame_num: got %0d required 2", got_q[0].fnum); end
      n_checks++; if (got_q[0].info_fnum !== 2'd2 || got_q[0].eof !== 1'b1) begin
        n_fail++; $display("FAIL eof_info: got fnum=%0d eof=%b required 2/1", got_q[0].info_fnum, got_q[0].eof); end
      n_checks++; if (got_q[0].cyc - c3 !== 1) begin n_fail++; $display("FAIL eof_latency: got %0d required 1", got_q[0].cyc - c3); end
    end
    got_q.delete();
    send_beat(32'h5A, 1'b1, 3, c);
    tvalid = 1'b0;
    wait_words(1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_word_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0].data !== 256'h5A || got_q[0].mask !== 8'h01) begin
        n_fail++; $display("FAIL single_beat: got mask=%h data=%h required 01/5a", got_q[0].mask, got_q[0].data); end
      n_checks++; if (got_q[0].fnum !== 2'd3) begin n_fail++; $display("FAIL single_fnum: got %0d required 3", got_q[0].fnum); end
    end
  endtask

  task automatic test_backpressure();
    int n_acc, stable_err;
    logic held_valid;
    logic [255:0] held;
    logic [7:0] held_mask;
    got_q.delete();
    o_ready = 1'b0;
    n_acc = 0; stable_err = 0; held_valid = 1'b0; held = '0; held_mask = '0;
    fork
      begin
        int c;
        for (int i = 0; i < 24; i++) begin
          send_beat(32'h100 + 32'(i), 1'b0, 0, c);
          n_acc++;
        end
        tvalid = 1'b0;
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (o_valid) begin
            if (!held_valid) begin
              held = o_data; held_mask = o_mask; held_valid = 1'b1;
            end else if (o_data !== held || o_mask !== held_mask) begin
              stable_err++;
            end
          end else if (held_valid) begin
            stable_err++;
          end
        end
        n_checks++; if (n_acc !== 16) begin n_fail++; $display("FAIL bp_accepted: got %0d beats required 16", n_acc); end
        n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready: got %b required 0", tready); end
        n_checks++; if (!held_valid || stable_err !== 0) begin
          n_fail++; $display("FAIL bp_stable: valid_seen=%b changes=%0d required 1/0", held_valid, stable_err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b required 1", busy); end
        o_ready = 1'b1;
      end
    join
    wait_words(3);
    repeat (10) @(negedge clk);
    n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL bp_word_count: got %0d required 3", got_q.size()); end
    if (got_q.size() >= 3) begin
      n_checks++; if (got_q[0].data !== 256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100) begin
        n_fail++; $display("FAIL bp_w0_data: got %h", got_q[0].data); end
      n_checks++; if (got_q[1].data !== 256'h0000010F_0000010E_0000010D_0000010C_0000010B_0000010A_00000109_00000108) begin
        n_fail++; $display("FAIL bp_w1_data: got %h", got_q[1].data); end
      n_checks++; if (got_q[2].data !== 256'h00000117_00000116_00000115_00000114_00000113_00000112_00000111_00000110) begin
        n_fail++; $display("FAIL bp_w2_data: got %h", got_q[2].data); end
      n_checks++; if (got_q[2].mask !== 8'hFF) begin n_fail++; $display("FAIL bp_w2_mask: got %h required ff", got_q[2].mask); end
    end
  endtask

  task automatic test_timeout();
    int c, c5;
    got_q.delete();
    o_ready = 1'b1;
    c5 = 0;
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h11 + 32'(i), 1'b0, 1, c);
      if (i == 4) c5 = c;
    end
    tvalid = 1'b0;
    wait_words(1);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL tmo_word_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0].mask !== 8'h1F) begin n_fail++; $display("FAIL tmo_mask: got %h required 1f", got_q[0].mask); end
      n_checks++; if (got_q[0].data !== 256'h00000015_00000014_00000013_00000012_00000011) begin
        n_fail++; $display("FAIL tmo_data: got %h", got_q[0].data); end
      n_checks++; if (got_q[0].cyc - c5 !== 11) begin n_fail++; $display("FAIL tmo_latency: got %0d required 11", got_q[0].cyc - c5); end
      n_checks++; if (got_q[0].fnum !== 2'd1 || got_q[0].eof !== 1'b0) begin
        n_fail++; $display("FAIL tmo_info: got fnum=%0d eof=%b required 1/0", got_q[0].fnum, got_q[0].eof); end
    end
  endtask

  task automatic test_reset_mid_word();
    int c;
    got_q.delete();
    o_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'hBAD0 + 32'(i), 1'b0, 1, c);
    tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0 || tready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_state: busy=%b tready=%b required 0/1", busy, tready); end
    for (int i = 0; i < 8; i++) send_beat(32'h20 + 32'(i), 1'b0, 1, c);
    tvalid = 1'b0;
    wait_words(1);
    repeat (15) @(negedge clk);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL rst_word_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++; if (got_q[0].data !== 256'h00000027_00000026_00000025_00000024_00000023_00000022_00000021_00000020) begin
        n_fail++; $display("FAIL rst_data: got %h", got_q[0].data); end
      n_checks++; if (got_q[0].mask !== 8'hFF) begin n_fail++; $display("FAIL rst_mask: got %h required ff", got_q[0].mask); end
    end
  endtask

  task automatic test_soft_clear();
    int c;
    got_q.delete();
    o_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(32'h30 + 32'(i), 1'b0, 3, c);
    for (int i = 0; i < 3; i++) send_beat(32'h40 + 32'(i), 1'b0, 3, c);
    tvalid = 1'b0;
    n_checks++; if (o_valid !== 1'b1 || frame_num !== 2'd3) begin
      n_fail++; $display("FAIL clr_pre: valid=%b fnum=%0d required 1/3", o_valid, frame_num); end
    settings.common.clear = 1'b1;
    @(negedge clk);
    settings.common.clear = 1'b0;
    n_checks++; if (o_valid !== 1'b0 || busy !== 1'b0 || tready !== 1'b1 || frame_num !== '0) begin
      n_fail++; $display("FAIL clr_post: valid=%b busy=%b tready=%b fnum=%0d required 0/0/1/0",
                         o_valid, busy, tready, frame_num); end
    o_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL clr_no_words: got %0d required 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_eof_partial();
    test_backpressure();
    test_timeout();
    test_reset_mid_word();
    test_soft_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
